// File: rtl/frame_stream_pkg.sv
// frame_stream_pkg: shared types, grayscale weights and helpers for the frame streamer
package frame_stream_pkg;

    typedef enum logic {
        MODE_COLOUR = 1'b0,
        MODE_GRAY   = 1'b1
    } mode_e;

    localparam int GRAY_KR = 77;
    localparam int GRAY_KG = 150;
    localparam int GRAY_KB = 29;

    typedef struct packed {
        logic        sop;
        logic        eop;
        mode_e       mode;
        logic [11:0] rgb444;
    } pixel_t;

    function automatic logic [9:0] expand4to10(input logic [3:0] n);
        return {n, n, 2'b00};
    endfunction

    // Only code 1 selects grayscale; every other request renders in colour
    function automatic mode_e to_mode(input logic [2:0] m);
        return (m == 3'd1) ? MODE_GRAY : MODE_COLOUR;
    endfunction

endpackage

// File: rtl/frame_stream_ctrl_fifo.sv
// pix_fifo2: two-entry skid FIFO of tagged pixels whose head register is the output stage
module pix_fifo2
    import frame_stream_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       push,
    input  logic       pop,
    input  pixel_t     din,
    output pixel_t     head,
    output logic [1:0] count
);

    pixel_t mem [2];
    logic   wp;
    logic   rp;

    // Storage, pointers and occupancy; clr drops everything queued
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp      <= ~wp;
            end
            if (pop) rp <= ~rp;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head = mem[rp];

endmodule

// File: rtl/frame_stream_ctrl.sv
// frame_stream_ctrl: raster frame-buffer reader streaming formatted pixels as Avalon-ST video packets
module frame_stream_ctrl
    import frame_stream_pkg::*;
#(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int AW     = 17
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    mode_req,
    input  logic          resync,
    output logic [AW-1:0] rd_addr,
    input  logic [11:0]   rd_data,
    output logic [29:0]   out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sop,
    output logic          out_eop,
    output logic [2:0]    mode_active,
    output logic          frame_done
);

    localparam logic [0:0]    RUN   = 1'b0;
    localparam logic [0:0]    FLUSH = 1'b1;
    localparam logic [AW-1:0] LAST  = AW'(WIDTH * HEIGHT - 1);

    logic [0:0] state;
    logic       inflight;
    logic       tag_sop;
    logic       tag_eop;
    mode_e      tag_mode;
    pixel_t     push_pix;
    pixel_t     head;
    logic [1:0] count;
    logic       pop;
    logic       issue;
    logic [9:0] r10;
    logic [9:0] g10;
    logic [9:0] b10;
    logic [9:0] gray;
    logic [17:0] luma;

    assign push_pix = '{sop: tag_sop, eop: tag_eop, mode: tag_mode, rgb444: rd_data};

    pix_fifo2 u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (resync),
        .push  (inflight),
        .pop   (pop),
        .din   (push_pix),
        .head  (head),
        .count (count)
    );

    // Handshake and fetch credit: a slot freed by this cycle's pop can be refilled at once,
    // which keeps the stream bubble-free while never exceeding two pixels in the pipeline
    always_comb begin
        out_valid  = count != 2'd0;
        pop        = out_valid && out_ready;
        issue      = (state == RUN) && ((3'(count) + 3'(inflight) - 3'(pop)) < 3'd2);
        out_sop    = out_valid && head.sop;
        out_eop    = out_valid && head.eop;
        frame_done = pop && head.eop;
    end

    // RGB444 to 30-bit output; grayscale luma replicated to all channels
    always_comb begin
        r10      = expand4to10(head.rgb444[11:8]);
        g10      = expand4to10(head.rgb444[7:4]);
        b10      = expand4to10(head.rgb444[3:0]);
        luma     = 18'(GRAY_KR) * 18'(r10) + 18'(GRAY_KG) * 18'(g10) + 18'(GRAY_KB) * 18'(b10);
        gray     = 10'(luma >> 8);
        out_data = (head.mode == MODE_GRAY) ? {gray, gray, gray} : {r10, g10, b10};
    end

    // Read sequencer: raster addresses, per-pixel tags, frame-boundary mode latch and resync flush
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            rd_addr     <= '0;
            inflight    <= 1'b0;
            tag_sop     <= 1'b0;
            tag_eop     <= 1'b0;
            tag_mode    <= MODE_COLOUR;
            mode_active <= 3'd0;
        end else if (resync) begin
            state    <= FLUSH;
            rd_addr  <= '0;
            inflight <= 1'b0;
        end else begin
            state    <= RUN;
            inflight <= issue;
            if (issue) begin
                rd_addr  <= (rd_addr == LAST) ? '0 : rd_addr + AW'(1);
                tag_sop  <= rd_addr == '0;
                tag_eop  <= rd_addr == LAST;
                tag_mode <= (rd_addr == '0) ? to_mode(mode_req) : to_mode(mode_active);
                if (rd_addr == '0) mode_active <= mode_req;
            end
        end
    end

endmodule
